// File: rtl/imem_loader_pkg.sv
// Shared types and byte-count constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } loader_state_t;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte packer: three stored bytes plus the incoming byte form the word,
// so the completed word is available combinationally on the edge taking its 4th byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [23:0] r_sr;
  logic [1:0]  r_cnt;

  assign o_word       = {r_sr, i_byte};
  assign o_word_valid = i_en && (r_cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_sr  <= {r_sr[15:0], i_byte};
      r_cnt <= r_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses count/payload/checksum byte stream, writes instruction RAM,
// and releases the core from reset only after a verified image.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [7:0]            IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  START,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_A,
  output logic [DATA_WIDTH-1:0] MEM_WD,
  output logic                  CPU_RST,
  output logic                  DONE,
  output logic                  ERR
);

  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;

  loader_state_t         r_state, w_state_nxt;
  logic [31:0]           r_count;
  logic [ADDR_WIDTH:0]   r_idx;
  logic [7:0]            r_xor;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_wd;

  logic                  w_xfer, w_clr, w_pk_en, w_word_valid, w_last_word;
  logic [31:0]           w_word;
  logic [ADDR_WIDTH:0]   w_idx_nxt;

  assign IN_READY = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
  assign DONE     = (r_state == S_DONE);
  assign ERR      = (r_state == S_ERR);
  assign CPU_RST  = (r_state != S_DONE);
  assign MEM_WE   = r_we;
  assign MEM_A    = r_a;
  assign MEM_WD   = r_wd;

  assign w_xfer      = IN_VALID && IN_READY;
  assign w_clr       = START && (DONE || ERR);
  assign w_pk_en     = w_xfer && ((r_state == S_HDR) || (r_state == S_DATA));
  assign w_idx_nxt   = r_idx + (ADDR_WIDTH + 1)'(1);
  assign w_last_word = (32'(w_idx_nxt) == r_count);

  // Header and payload share the packer; its counter wraps to 0 at the HDR->DATA boundary.
  byte_packer u_packer (
    .clk          (CLK),
    .rst_n        (RST_N),
    .i_clr        (w_clr),
    .i_en         (w_pk_en),
    .i_byte       (IN_DATA),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_HDR;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR: if (w_word_valid) begin
        if ({1'b0, w_word} > MAX_WORDS) w_state_nxt = S_ERR;
        else if (w_word == 32'd0)       w_state_nxt = S_CSUM;
        else                            w_state_nxt = S_DATA;
      end
      S_DATA: if (w_word_valid && w_last_word) w_state_nxt = S_CSUM;
      S_CSUM: if (w_xfer) w_state_nxt = (IN_DATA == r_xor) ? S_DONE : S_ERR;
      S_DONE, S_ERR: if (START) w_state_nxt = S_HDR;
      default: w_state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count <= '0;
      r_idx   <= '0;
      r_xor   <= '0;
      r_we    <= 1'b0;
      r_a     <= '0;
      r_wd    <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_clr) begin
        r_count <= '0;
        r_idx   <= '0;
        r_xor   <= '0;
      end else begin
        if (r_state == S_HDR && w_word_valid) r_count <= w_word;
        if (r_state == S_DATA && w_xfer) r_xor <= r_xor ^ IN_DATA;
        if (r_state == S_DATA && w_word_valid) begin
          r_we  <= 1'b1;
          r_a   <= r_idx[ADDR_WIDTH-1:0];
          r_wd  <= w_word;
          r_idx <= w_idx_nxt;
        end
      end
    end
  end

endmodule
